byte_bus_responder: RTL and testbench
=====================================

Name: byte_bus_responder

Overview:
- Target-side end of the 8-bit byte-serial CPU bus. The CPU-side handler serializes a 32-bit address and write word as 4 byte beats, then collects a 32-bit word as 4 byte beats.
- This block deserializes address and write data, issues one word-wide request to a local memory/peripheral port, and serializes the returned word back onto the bus.
- Adds a bus_ready qualifier so the initiator can stall during memory latency.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in MEM before abort (used only with the optional feature).
- ERR_WORD, 32'hDEAD_BEEF, word returned on timeout abort (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- bus_start  input  1  one-cycle pulse marking slot 0 of a frame
- bus_rw  input  1  1=write, 0=read; sampled with bus_start
- bus_addr  input  8  address byte beat
- bus_wdata  input  8  write-data byte beat
- bus_ready  output  1  high only during the 4 response beats
- bus_rdata  output  8  response byte beat
- bus_rdata_oe  output  1  response byte driven (read frames only)
- mem_req  output  1  memory request, held until acked
- mem_we  output  1  write enable for request
- mem_addr  output  32  assembled address
- mem_wdata  output  32  assembled write word
- mem_rdata  input  32  read word, valid with mem_ack
- mem_ack  input  1  request completion
- proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; shift registers, beat counter and proto_err cleared. A reset mid-frame drops mem_req in the same instant; the frame is lost.
- Byte order is little-endian with clean slices: beat0=[7:0], beat1=[15:8], beat2=[23:16], beat3=[31:24].
- IDLE:
  - bus_start=1 in cycle T: latch bus_rw, clear beat counter, go to ADDR.
- ADDR:
  - Capture bus_addr and bus_wdata at the edges ending cycles T+1..T+4 (beats 0..3).
  - After beat 3, go to MEM.
  - bus_start is ignored here.
- MEM:
  - Enter in cycle T+5 with mem_req=1, mem_we=latched rw, and mem_addr/mem_wdata stable.
  - Stay while mem_ack=0.
  - mem_ack=1 in a cycle with mem_req=1 completes the request: latch mem_rdata (reads) or 0 (writes), drop mem_req next cycle, go to RESP.
  - mem_ack while mem_req=0 is ignored.
  - Minimum latency: ack at T+5 puts the first response beat at T+6.
- RESP (4 cycles, D..D+3):
  - bus_ready=1 and bus_rdata=byte k in cycle D+k.
  - bus_rdata_oe=1 only for read frames; write frames drive bus_rdata=8'h00, oe=0.
  - After D+3, return to IDLE. bus_ready, oe and rdata return to 0.
- Back-to-back: the earliest accepted bus_start is cycle D+4.
- proto_err:
  - Set (sticky until rst) by bus_start in any state other than IDLE, including the cycle D+3.
  - The offending pulse is ignored and the current frame continues unaffected.
- Outputs are registered; no combinational path from bus inputs to bus outputs.

Optional Feature:
- Macro: BYTE_BUS_RESP_TIMEOUT_EN.
- Defined:
  - A counter runs while in MEM.
  - If TIMEOUT_CYCLES cycles elapse without mem_ack, drop mem_req, set the sticky output timeout_err (extra 1-bit port), and go to RESP returning ERR_WORD with oe following rw.
  - A late mem_ack after abort is ignored.
- Undefined:
  - No counter and no timeout_err port; MEM waits indefinitely.

Test Plan:
- Read, zero wait:
  - Stimulus: start with rw=0, addr beats 78,56,34,12; mem_ack at T+5 with mem_rdata=0xCAFEF00D.
  - Required: mem_addr=0x12345678, mem_we=0, mem_req high exactly 1 cycle; bus_rdata 0D,F0,FE,CA at T+6..T+9 with bus_ready=1 and oe=1.
- Write with 3-cycle wait:
  - Stimulus: rw=1, addr 0x00000010, wdata beats EF,BE,AD,DE; mem_ack at T+8.
  - Required: mem_wdata=0xDEADBEEF and mem_we=1 held T+5..T+8; 4 beats of bus_ready with rdata=00 and oe=0 at T+9..T+12.
- Back-to-back frames:
  - Stimulus: second bus_start at D+4.
  - Required: accepted; proto_err stays 0. A start at D+3 instead is ignored and sets proto_err=1.
- Reset mid-operation:
  - Stimulus: assert rst while in MEM with mem_req=1.
  - Required: mem_req, bus_ready and proto_err go to 0 without waiting for a clock edge; the next start frames normally.
- Timeout (with BYTE_BUS_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: no mem_ack.
  - Required: mem_req drops after 4 cycles; timeout_err=1; bus_rdata EF,BE,AD,DE for a read.
  - A later ack has no effect.

Source files
------------

// File: rtl/byte_bus_responder_if.sv
// Bus-side and memory-side signal bundle for byte_bus_responder.
// The slave modport is the responder's view; master is the initiator/memory environment.
interface byte_bus_responder_if;
    logic        bus_start;
    logic        bus_rw;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ready;
    logic [7:0]  bus_rdata;
    logic        bus_rdata_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  bus_start, bus_rw, bus_addr, bus_wdata, mem_rdata, mem_ack,
        output bus_ready, bus_rdata, bus_rdata_oe, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output bus_start, bus_rw, bus_addr, bus_wdata, mem_rdata, mem_ack,
        input  bus_ready, bus_rdata, bus_rdata_oe, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/byte_bus_responder.sv
// Target end of the 8-bit byte-serial bus: collects 4 address/data beats, issues one word
// request, then returns the word as 4 bytes. Define BYTE_BUS_RESP_TIMEOUT_EN for the MEM abort.
module byte_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    byte_bus_responder_if.slave   bus,
    output logic                  proto_err
`ifdef BYTE_BUS_RESP_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, MEM, RESP} state_t;

    state_t      state;
    logic        rw;
    logic [1:0]  beat;
    logic [23:0] resp_shift;
    logic [31:0] resp_word;
    logic        timed_out;

`ifdef BYTE_BUS_RESP_TIMEOUT_EN
    logic [31:0] mem_cycles;

    assign timed_out = (state == MEM) && !bus.mem_ack
                       && (mem_cycles == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cycles  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == MEM && !bus.mem_ack)
                mem_cycles <= mem_cycles + 32'd1;
            else
                mem_cycles <= '0;
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Writes answer with zeros; an aborted request answers with ERR_WORD.
    always_comb begin
        resp_word = bus.mem_rdata;
        if (timed_out)
            resp_word = ERR_WORD;
        else if (rw)
            resp_word = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rw               <= 1'b0;
            beat             <= '0;
            resp_shift       <= '0;
            proto_err        <= 1'b0;
            bus.bus_ready    <= 1'b0;
            bus.bus_rdata    <= '0;
            bus.bus_rdata_oe <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
        end else begin
            if (bus.bus_start && state != IDLE)
                proto_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.bus_start) begin
                        rw    <= bus.bus_rw;
                        beat  <= '0;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    // Little-endian: after four shifts beat 0 lands in [7:0].
                    bus.mem_addr  <= {bus.bus_addr, bus.mem_addr[31:8]};
                    bus.mem_wdata <= {bus.bus_wdata, bus.mem_wdata[31:8]};
                    beat          <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        bus.mem_req <= 1'b1;
                        bus.mem_we  <= rw;
                        state       <= MEM;
                    end
                end
                MEM: begin
                    if (bus.mem_ack || timed_out) begin
                        bus.mem_req      <= 1'b0;
                        bus.mem_we       <= 1'b0;
                        bus.bus_ready    <= 1'b1;
                        bus.bus_rdata    <= resp_word[7:0];
                        bus.bus_rdata_oe <= ~rw;
                        resp_shift       <= resp_word[31:8];
                        beat             <= '0;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        bus.bus_ready    <= 1'b0;
                        bus.bus_rdata    <= '0;
                        bus.bus_rdata_oe <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        bus.bus_rdata <= resp_shift[7:0];
                        resp_shift    <= {8'h00, resp_shift[23:8]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_bus_responder.sv
// Self-checking bench for byte_bus_responder: a per-cycle timeline model of the expected
// outputs, filled frame by frame from the bus rules and compared on every falling edge.
module tb_byte_bus_responder;

    localparam int          N   = 1024;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic proto_err;
`ifdef BYTE_BUS_RESP_TIMEOUT_EN
    logic timeout_err;
`endif

    byte_bus_responder_if bus();

    byte_bus_responder #(
        .TIMEOUT_CYCLES(4),
        .ERR_WORD(ERR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .proto_err(proto_err)
`ifdef BYTE_BUS_RESP_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic        exp_ready [N];
    logic [7:0]  exp_rdata [N];
    logic        exp_oe    [N];
    logic        exp_req   [N];
    logic        exp_we    [N];
    logic [31:0] exp_addr  [N];
    logic [31:0] exp_wdata [N];
    logic        exp_perr  [N];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset(input int from);
        for (int c = from; c < N; c++) begin
            exp_ready[c] = 1'b0;
            exp_rdata[c] = 8'h00;
            exp_oe[c]    = 1'b0;
            exp_req[c]   = 1'b0;
            exp_we[c]    = 1'b0;
            exp_addr[c]  = '0;
            exp_wdata[c] = '0;
            exp_perr[c]  = 1'b0;
        end
    endfunction

    // Request held T+5..T+5+wt, response bytes at T+6+wt onward, least significant first.
    function automatic void model_frame(input int t, input bit rw, input logic [31:0] a,
                                        input logic [31:0] w, input int wt, input logic [31:0] word);
        for (int c = t + 5; c <= t + 5 + wt; c++) begin
            exp_req[c]   = 1'b1;
            exp_we[c]    = rw;
            exp_addr[c]  = a;
            exp_wdata[c] = w;
        end
        for (int k = 0; k < 4; k++) begin
            exp_ready[t + 6 + wt + k] = 1'b1;
            exp_rdata[t + 6 + wt + k] = word[8*k +: 8];
            exp_oe[t + 6 + wt + k]    = !rw;
        end
    endfunction

    function automatic void model_proto_err(input int x);
        for (int c = x + 1; c < N; c++) exp_perr[c] = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (checking && !rst && cyc < N) begin
            checkOutput("bus_ready", {31'b0, bus.bus_ready}, {31'b0, exp_ready[cyc]});
            checkOutput("bus_rdata", {24'b0, bus.bus_rdata}, {24'b0, exp_rdata[cyc]});
            checkOutput("bus_rdata_oe", {31'b0, bus.bus_rdata_oe}, {31'b0, exp_oe[cyc]});
            checkOutput("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req[cyc]});
            checkOutput("proto_err", {31'b0, proto_err}, {31'b0, exp_perr[cyc]});
            if (exp_req[cyc]) begin
                checkOutput("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_we[cyc]});
                checkOutput("mem_addr", bus.mem_addr, exp_addr[cyc]);
                checkOutput("mem_wdata", bus.mem_wdata, exp_wdata[cyc]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives bus_start in cycle T and beats in T+1..T+4; returns in cycle T+5.
    task automatic applyStimulus(input bit rw, input logic [31:0] a, input logic [31:0] w,
                                 output int t);
        logic [31:0] av;
        logic [31:0] wv;
        av = a;
        wv = w;
        t = cyc;
        bus.bus_start = 1'b1;
        bus.bus_rw    = rw;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.bus_start = 1'b0;
            bus.bus_rw    = 1'b0;
            bus.bus_addr  = av[8*k +: 8];
            bus.bus_wdata = wv[8*k +: 8];
        end
        tick();
        bus.bus_addr  = 8'h00;
        bus.bus_wdata = 8'h00;
    endtask

    // Acks after wt wait cycles; returns in the first response cycle D.
    task automatic finishFrame(input int t, input bit rw, input logic [31:0] a, input logic [31:0] w,
                               input int wt, input logic [31:0] rdata);
        model_frame(t, rw, a, w, wt, rw ? 32'h0 : rdata);
        repeat (wt) tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        logic [7:0] rd_bytes [4];
        rd_bytes = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        model_reset(0);
        bus.bus_start = 1'b0;
        bus.bus_rw    = 1'b0;
        bus.bus_addr  = 8'h00;
        bus.bus_wdata = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        #1 rst = 1'b1;
        #1;
        checkOutput("rst_bus_ready", {31'b0, bus.bus_ready}, 32'd0);
        checkOutput("rst_bus_rdata", {24'b0, bus.bus_rdata}, 32'd0);
        checkOutput("rst_oe", {31'b0, bus.bus_rdata_oe}, 32'd0);
        checkOutput("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_proto_err", {31'b0, proto_err}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        checking = 1'b1;
        tick();

        $display("[TB] read, zero wait");
        applyStimulus(1'b0, 32'h1234_5678, 32'h0, t);
        checkOutput("rd0_mem_addr", bus.mem_addr, 32'h1234_5678);
        checkOutput("rd0_mem_we", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("rd0_mem_req", {31'b0, bus.mem_req}, 32'd1);
        finishFrame(t, 1'b0, 32'h1234_5678, 32'h0, 0, 32'hCAFE_F00D);
        checkOutput("rd0_latency", cyc, t + 6);
        for (int k = 0; k < 4; k++) begin
            checkOutput("rd0_byte", {24'b0, bus.bus_rdata}, {24'b0, rd_bytes[k]});
            checkOutput("rd0_oe", {31'b0, bus.bus_rdata_oe}, 32'd1);
            tick();
        end

        $display("[TB] write, 3-cycle wait, back-to-back with previous frame");
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, t);
        checkOutput("wr_mem_we", {31'b0, bus.mem_we}, 32'd1);
        checkOutput("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        finishFrame(t, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h1122_3344);
        checkOutput("wr_latency", cyc, t + 9);
        checkOutput("wr_rdata", {24'b0, bus.bus_rdata}, 32'h00);
        checkOutput("wr_oe", {31'b0, bus.bus_rdata_oe}, 32'd0);
        checkOutput("wr_ready", {31'b0, bus.bus_ready}, 32'd1);

        $display("[TB] back-to-back start at D+4");
        repeat (4) tick();
        applyStimulus(1'b0, 32'hA5A5_0001, 32'h0, t);
        finishFrame(t, 1'b0, 32'hA5A5_0001, 32'h0, 1, 32'h0102_0304);
        checkOutput("b2b_proto_err", {31'b0, proto_err}, 32'd0);

        $display("[TB] start during D+3 is ignored and flagged");
        repeat (3) tick();
        bus.bus_start = 1'b1;
        bus.bus_rw    = 1'b1;
        model_proto_err(cyc);
        tick();
        bus.bus_start = 1'b0;
        bus.bus_rw    = 1'b0;
        checkOutput("late_proto_err", {31'b0, proto_err}, 32'd1);
        checkOutput("late_ready", {31'b0, bus.bus_ready}, 32'd0);
        repeat (6) tick();

        $display("[TB] reset while in MEM");
        applyStimulus(1'b0, 32'h0BAD_F00D, 32'h0, t);
        model_frame(t, 1'b0, 32'h0BAD_F00D, 32'h0, 1, 32'h0);
        tick();
        tick();
        checkOutput("pre_rst_mem_req", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("async_rst_ready", {31'b0, bus.bus_ready}, 32'd0);
        checkOutput("async_rst_proto_err", {31'b0, proto_err}, 32'd0);
        model_reset(cyc);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h8765_4321, 32'h0, t);
        finishFrame(t, 1'b0, 32'h8765_4321, 32'h0, 2, 32'h55AA_33CC);
        checkOutput("post_rst_byte0", {24'b0, bus.bus_rdata}, 32'hCC);
        repeat (6) tick();

`ifdef BYTE_BUS_RESP_TIMEOUT_EN
        $display("[TB] timeout abort");
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, t);
        model_frame(t, 1'b0, 32'h0000_0020, 32'h0, 3, ERR);
        repeat (4) tick();
        checkOutput("to_latency", cyc, t + 9);
        checkOutput("to_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("to_err", {31'b0, timeout_err}, 32'd1);
        checkOutput("to_byte0", {24'b0, bus.bus_rdata}, 32'hEF);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        checkOutput("to_byte2", {24'b0, bus.bus_rdata}, 32'hAD);
        repeat (6) tick();
        checkOutput("to_err_sticky", {31'b0, timeout_err}, 32'd1);
`endif

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
